packed_dup_unpacker: RTL and testbench
======================================

// Module: packed_dup_unpacker
// PURPOSE
//   Receive side of the duplicated packed-word path. The producer drives a
//   word of the form {w, w}, where w is a nested packed array of NELEM
//   elements, each ELEM_W bits wide (2x2x2 nesting of 2-bit elements at
//   defaults). This block accepts one such word over a valid/ready handshake.
//   It checks that the two copies agree, then streams the elements of w one
//   per handshake, tagged with their flat index. It sits between the
//   duplicating packer and element-wise consumers and checkers.
// PARAMETERS
//   ELEM_W  2  width of one leaf element (innermost packed dimension)
//   NELEM   8  leaf elements per w; power of 2, >= 2; W = ELEM_W*NELEM = 16
// PORTS
//   clk           in   1              single clock, rising edge
//   rst_n         in   1              asynchronous, active-low reset
//   in_valid      in   1              input word valid
//   in_ready      out  1              block can accept a word
//   in_data       in   2*W            {hi copy, lo copy}; lo = in_data[W-1:0]
//   out_valid     out  1              element valid
//   out_ready     in   1              consumer accepts element
//   out_elem      out  ELEM_W         current element
//   out_idx       out  $clog2(NELEM)  flat element index, 0..NELEM-1
//   out_last      out  1              out_idx == NELEM-1
//   out_mismatch  out  1              hi != lo for the word being streamed
//   err_count     out  8              mismatched words accepted, saturating
// BEHAVIOUR
//   - Reset (async assert): state IDLE, out_valid=0, out_idx=0, out_elem=0,
//     out_mismatch=0, err_count=0. in_ready=1 once rst_n is high.
//   - States: IDLE and STREAM.
//   - IDLE:
//     - in_ready=1 and out_valid=0.
//     - When in_valid=1, latch lo into a W-bit shift register and set
//       mismatch = (hi != lo).
//     - Go to STREAM with out_idx=0.
//   - STREAM:
//     - out_valid=1 and out_elem = shreg[ELEM_W-1:0].
//     - Element i is w[i*ELEM_W +: ELEM_W], streamed LSB element first.
//     - Nested index: out_idx MSB is the outermost dimension and LSB is the
//       innermost one. Example: idx 5 = 3'b101 -> outer 1, middle 0, inner 1.
//   - Element handshake (out_valid && out_ready):
//     - shift shreg right by ELEM_W and increment out_idx.
//     - On the out_last beat, return to IDLE.
//   - Stall (out_valid=1, out_ready=0): out_elem, out_idx, out_last and
//     out_mismatch hold stable.
//   - Back-to-back words:
//     - in_ready = IDLE | (STREAM & out_last & out_ready); this path is
//       combinational from out_ready.
//     - A word accepted on the last beat loads directly and stays in STREAM
//       with out_idx=0 next cycle. There is no bubble.
//   - Latency: word accepted at cycle N -> element 0 valid at N+1. A word
//     takes NELEM cycles with no backpressure.
//   - The hi copy is used only for the compare and is never streamed.
//   - out_mismatch is held for every beat of its word.
//   - err_count increments by 1 per accepted word with a mismatch and
//     saturates at 255.
//   - in_valid while in_ready=0 is ignored. The producer must hold in_data
//     until it is accepted.
//   - Reset mid-stream: the remaining elements are dropped, out_valid falls
//     immediately, and err_count clears.
// TESTING
//   1. in_data=32'hE4E4_E4E4, out_ready=1 -> elems 0,1,2,3,0,1,2,3 at idx 0..7;
//      out_last only at idx 7; out_mismatch=0; err_count=0.
//   2. in_data={16'h0000,16'hFFFF} -> 8 beats of elem 3, out_mismatch=1 on
//      all beats, err_count=1.
//   3. Word 16'h1B1B duplicated, out_ready=0 for 5 cycles at idx 3 ->
//      out_idx=3, out_elem=0 held stable; the stream then resumes with idx 4.
//   4. Second word presented during the idx-7 beat, out_ready=1 -> in_ready=1
//      that cycle, next cycle out_idx=0 with the new data, no idle cycle.
//   5. 260 consecutive mismatched words -> err_count reaches 255 and stays
//      at 255.
//   6. rst_n low at idx 4 -> out_valid=0 that same cycle; after release
//      in_ready=1, out_idx=0, err_count=0.

Source files
------------

// File: rtl/packed_dup_unpacker.sv
// rtl/packed_dup_unpacker.sv - receive side of the duplicated packed-word path
//
// Accepts one word {hi, lo} (each W = ELEM_W*NELEM bits) on a valid/ready
// handshake. It compares the two copies, then streams the leaf elements of
// lo one per handshake, LSB element first, each tagged with its flat index.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       input word valid
//   in_ready       block can accept a word
//   in_data        {hi copy, lo copy}; only lo is streamed
//   out_valid      element valid
//   out_ready      consumer accepts element
//   out_elem       current element
//   out_idx        flat element index; MSB = outermost nesting dimension
//   out_last       asserted on the final element of the word
//   out_mismatch   hi != lo for the word being streamed
//   err_count      saturating count of mismatched words accepted
module packed_dup_unpacker #(
    parameter int ELEM_W = 2,
    parameter int NELEM  = 8,
    localparam int W     = ELEM_W * NELEM,
    localparam int IDX_W = $clog2(NELEM)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*W-1:0]    in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_elem,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              out_mismatch,
    output logic [7:0]        err_count
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [W-1:0]     r_shreg;
    logic [IDX_W-1:0] r_idx;
    logic             r_mismatch;
    logic [7:0]       r_err_count;

    logic             w_accept;
    logic             w_beat;
    logic             w_last;
    logic [W-1:0]     w_lo;
    logic [W-1:0]     w_hi;

    assign w_lo     = in_data[W-1:0];
    assign w_hi     = in_data[2*W-1:W];
    assign w_last   = (r_state == S_STREAM) && (r_idx == IDX_W'(NELEM - 1));
    assign w_beat   = out_valid && out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready is combinational from out_ready so a new word can be taken on
    // the last beat of the current one without an idle cycle in between.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                out_valid = 1'b1;
                in_ready  = w_last && out_ready;
                if (w_last && out_ready) begin
                    w_state_nxt = in_valid ? S_STREAM : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A load takes priority over a shift: when both happen on the last beat,
    // the old word is finished and the new word replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg     <= '0;
            r_idx       <= '0;
            r_mismatch  <= 1'b0;
            r_err_count <= 8'd0;
        end else if (w_accept) begin
            r_shreg    <= w_lo;
            r_idx      <= '0;
            r_mismatch <= (w_hi != w_lo);
            if ((w_hi != w_lo) && (r_err_count != 8'hFF)) begin
                r_err_count <= r_err_count + 8'd1;
            end
        end else if (w_beat) begin
            r_shreg <= r_shreg >> ELEM_W;
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

    assign out_elem     = r_shreg[ELEM_W-1:0];
    assign out_idx      = r_idx;
    assign out_last     = w_last;
    assign out_mismatch = r_mismatch;
    assign err_count    = r_err_count;

endmodule

// File: tb/tb_packed_dup_unpacker.sv
// tb/tb_packed_dup_unpacker.sv - directed self-checking bench for packed_dup_unpacker
module tb_packed_dup_unpacker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_elem;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        out_mismatch;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    int e_e4 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int e_1b [8] = '{3, 2, 1, 0, 3, 2, 1, 0};
    int e_a5 [8] = '{1, 1, 2, 2, 1, 1, 2, 2};
    int exp_err;

    packed_dup_unpacker #(.ELEM_W(2), .NELEM(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_elem     (out_elem),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .out_mismatch (out_mismatch),
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input int idx, input int elem, input logic mm);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " idx"}, 32'(out_idx), 32'(idx));
        chk({tag, " elem"}, 32'(out_elem), 32'(elem));
        chk({tag, " last"}, 32'(out_last), 32'(idx == 7));
        chk({tag, " mismatch"}, 32'(out_mismatch), 32'(mm));
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b1;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_idx", 32'(out_idx), 32'd0);
        chk("rst out_elem", 32'(out_elem), 32'd0);
        chk("rst out_mismatch", 32'(out_mismatch), 32'd0);
        chk("rst err_count", 32'(err_count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);

        // 1: matched word, in_valid during stream must be ignored
        in_valid = 1'b1;
        in_data  = 32'hE4E4_E4E4;
        #1;
        chk("t1 idle out_valid", 32'(out_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i >= 2 && i <= 4) begin
                in_valid = 1'b1;
                in_data  = 32'h0000_FFFF;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            chk_beat("t1", i, e_e4[i], 1'b0);
            if (i < 7) chk("t1 in_ready mid", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        #1;
        chk("t1 done out_valid", 32'(out_valid), 32'd0);
        chk("t1 err_count", 32'(err_count), 32'd0);

        // 2: mismatched word
        in_valid = 1'b1;
        in_data  = {16'h0000, 16'hFFFF};
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_beat("t2", i, 3, 1'b1);
            chk("t2 err_count", 32'(err_count), 32'd1);
            tick();
        end

        // 3: stall at idx 3 for 5 cycles
        in_valid = 1'b1;
        in_data  = 32'h1B1B_1B1B;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    #1;
                    chk_beat("t3 stall", 3, 0, 1'b0);
                    tick();
                end
                out_ready = 1'b1;
            end
            #1;
            chk_beat("t3", i, e_1b[i], 1'b0);
            tick();
        end

        // 4: back-to-back words, second presented on the last beat
        in_valid = 1'b1;
        in_data  = 32'hE4E4_E4E4;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                in_valid = 1'b1;
                in_data  = 32'hA5A5_A5A5;
            end
            #1;
            chk_beat("t4 w0", i, e_e4[i], 1'b0);
            if (i == 7) chk("t4 in_ready last", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk_beat("t4 w1", i, e_a5[i], 1'b0);
            tick();
        end
        #1;
        chk("t4 done out_valid", 32'(out_valid), 32'd0);

        // 5: 260 consecutive mismatched words, err_count starts at 1
        exp_err  = 1;
        in_valid = 1'b1;
        in_data  = {16'h1234, 16'h4321};
        tick();
        exp_err++;
        chk("t5 err first", 32'(err_count), 32'(exp_err));
        for (int k = 2; k <= 260; k++) begin
            repeat (8) tick();
            if (exp_err < 255) exp_err++;
            chk("t5 err", 32'(err_count), 32'(exp_err));
            chk("t5 idx0", 32'(out_idx), 32'd0);
        end
        in_valid = 1'b0;
        repeat (8) tick();
        chk("t5 final err", 32'(err_count), 32'd255);
        chk("t5 drained", 32'(out_valid), 32'd0);

        // 6: reset mid-stream at idx 4
        in_valid = 1'b1;
        in_data  = 32'hE4E4_E4E4;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk_beat("t6 pre", 4, 0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t6 rst out_valid", 32'(out_valid), 32'd0);
        chk("t6 rst err_count", 32'(err_count), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("t6 in_ready", 32'(in_ready), 32'd1);
        chk("t6 out_idx", 32'(out_idx), 32'd0);
        chk("t6 err_count", 32'(err_count), 32'd0);
        chk("t6 out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'hA5A5_A5A5;
        tick();
        in_valid = 1'b0;
        #1;
        chk_beat("t6 after", 0, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
